// File: rtl/prim_util_pkg.sv
// Shared elaboration-time helpers for the prim_* library.
// vbits returns the number of bits needed to index 'value' items, never less than one.
package prim_util_pkg;

  function automatic integer vbits(integer value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/prim_fifo_wm_event.sv
// Turns a watermark level into a registered one-cycle pulse on its rising edge.
// A synchronous clear forgets the history, so a level that is still true pulses again.
module prim_fifo_wm_event (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic level_i,
  output logic evt_o
);

  logic hist_q;
  logic evt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
      evt_q  <= 1'b0;
    end else if (clr_i) begin
      hist_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      hist_q <= level_i;
      evt_q  <= level_i & ~hist_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Synchronous FIFO with programmable high/low watermarks, rising-edge watermark
// events and a peak-occupancy tracker; supports non-power-of-two depths.
module prim_fifo_sync_wm
  import prim_util_pkg::*;
#(
  parameter int unsigned Width             = 16,
  parameter int unsigned Depth             = 8,
  parameter bit          Pass              = 1'b1,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  localparam int unsigned DepthW           = vbits(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  input  logic [DepthW-1:0] wm_hi_i,
  input  logic [DepthW-1:0] wm_lo_i,
  output logic              wm_hi_o,
  output logic              wm_lo_o,
  output logic              wm_hi_evt_o,
  output logic              wm_lo_evt_o,
  input  logic              peak_clr_i,
  output logic [DepthW-1:0] peak_o
);

  localparam int unsigned PTRV_W = vbits(Depth);

  if (Depth == 0) begin : gen_depth_chk
    $error("prim_fifo_sync_wm: Depth must be >= 1");
  end

  // The extra MSB toggles on every wrap so full and empty can be told apart.
  function automatic logic [PTRV_W:0] ptr_inc(logic [PTRV_W:0] ptr);
    logic [PTRV_W:0] nxt;
    if (ptr[PTRV_W-1:0] == PTRV_W'(Depth - 1)) begin
      nxt = {~ptr[PTRV_W], {PTRV_W{1'b0}}};
    end else begin
      nxt = {ptr[PTRV_W], ptr[PTRV_W-1:0] + PTRV_W'(1)};
    end
    return nxt;
  endfunction

  logic [PTRV_W:0]   wptr_q, rptr_q;
  logic [PTRV_W-1:0] widx, ridx;
  logic              under_rst_q;
  logic              empty, full;
  logic              push, pop;
  logic [DepthW-1:0] depth;
  logic [DepthW-1:0] peak_q;
  logic [Width-1:0]  storage_q [Depth];
  logic [Width-1:0]  rdata_raw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      under_rst_q <= 1'b1;
    end else begin
      under_rst_q <= 1'b0;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q == {~rptr_q[PTRV_W], rptr_q[PTRV_W-1:0]});

  assign wready_o = ~under_rst_q & ~full;
  assign rvalid_o = ~under_rst_q & (~empty | (Pass & wvalid_i));
  assign push     = wvalid_i & wready_o;
  assign pop      = rvalid_o & rready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

  if (Depth == 1) begin : gen_idx_single
    assign widx = '0;
    assign ridx = '0;
  end else begin : gen_idx_multi
    assign widx = wptr_q[PTRV_W-1:0];
    assign ridx = rptr_q[PTRV_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      storage_q <= '{default: '0};
    end else if (push) begin
      storage_q[widx] <= wdata_i;
    end
  end

  // Flow-through: when empty, the write port is presented directly on the read port.
  assign rdata_raw = (Pass && empty) ? wdata_i : storage_q[ridx];
  assign rdata_o   = (under_rst_q || (OutputZeroIfEmpty && !rvalid_o)) ? '0 : rdata_raw;

  always_comb begin
    depth = '0;
    if (full) begin
      depth = DepthW'(Depth);
    end else if (wptr_q[PTRV_W] == rptr_q[PTRV_W]) begin
      depth = DepthW'(wptr_q[PTRV_W-1:0]) - DepthW'(rptr_q[PTRV_W-1:0]);
    end else begin
      depth = DepthW'(Depth) - DepthW'(rptr_q[PTRV_W-1:0]) + DepthW'(wptr_q[PTRV_W-1:0]);
    end
  end

  assign depth_o = depth;
  assign full_o  = full;

  assign wm_hi_o = (wm_hi_i != '0) && (depth >= wm_hi_i);
  assign wm_lo_o = (depth <= wm_lo_i);

  prim_fifo_wm_event u_hi_evt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .level_i (wm_hi_o),
    .evt_o   (wm_hi_evt_o)
  );

  prim_fifo_wm_event u_lo_evt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .level_i (wm_lo_o),
    .evt_o   (wm_lo_evt_o)
  );

  // Peak is sampled from the current occupancy, so it lags depth_o by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else if (clr_i || peak_clr_i) begin
      peak_q <= '0;
    end else if (depth > peak_q) begin
      peak_q <= depth;
    end
  end

  assign peak_o = peak_q;

`ifndef SYNTHESIS
  a_depth_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    depth_o <= DepthW'(Depth));
  a_rdata_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> !$isunknown(rdata_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !full);
  a_hi_evt_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wm_hi_evt_o |=> !wm_hi_evt_o);
`endif

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Self-checking bench for prim_fifo_sync_wm: a hand-derived vector table, directed
// corner sequences and random traffic checked against a queue-based reference model.
module tb_prim_fifo_sync_wm;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int DW  = 3;
  localparam int D3W = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clr_i, wvalid_i, rready_i, peak_clr_i;
  logic [W-1:0]  wdata_i;
  logic [DW-1:0] wm_hi_i, wm_lo_i;
  logic          wready_o, rvalid_o, full_o, wm_hi_o, wm_lo_o, wm_hi_evt_o, wm_lo_evt_o;
  logic [W-1:0]  rdata_o;
  logic [DW-1:0] depth_o, peak_o;

  logic           d3_clr, d3_wvalid, d3_rready, d3_peak_clr;
  logic [W-1:0]   d3_wdata, d3_rdata;
  logic [D3W-1:0] d3_wm_hi, d3_wm_lo, d3_depth, d3_peak;
  logic           d3_wready, d3_rvalid, d3_full, d3_wm_hi_lvl, d3_wm_lo_lvl, d3_hi_evt, d3_lo_evt;

  always #5 clk_i = ~clk_i;

  prim_fifo_sync_wm #(.Width(W), .Depth(D), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
    .full_o(full_o), .depth_o(depth_o), .wm_hi_i(wm_hi_i), .wm_lo_i(wm_lo_i),
    .wm_hi_o(wm_hi_o), .wm_lo_o(wm_lo_o), .wm_hi_evt_o(wm_hi_evt_o), .wm_lo_evt_o(wm_lo_evt_o),
    .peak_clr_i(peak_clr_i), .peak_o(peak_o)
  );

  prim_fifo_sync_wm #(.Width(W), .Depth(3), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(d3_clr),
    .wvalid_i(d3_wvalid), .wready_o(d3_wready), .wdata_i(d3_wdata),
    .rvalid_o(d3_rvalid), .rready_i(d3_rready), .rdata_o(d3_rdata),
    .full_o(d3_full), .depth_o(d3_depth), .wm_hi_i(d3_wm_hi), .wm_lo_i(d3_wm_lo),
    .wm_hi_o(d3_wm_hi_lvl), .wm_lo_o(d3_wm_lo_lvl), .wm_hi_evt_o(d3_hi_evt), .wm_lo_evt_o(d3_lo_evt),
    .peak_clr_i(d3_peak_clr), .peak_o(d3_peak)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state: the FIFO contents as a plain queue plus watermark history.
  int q[$];
  bit m_ur;
  int m_peak;
  bit hi_seen, lo_seen, m_hi_evt, m_lo_evt;

  bit s_wv, s_rr, s_clr, s_pclr;
  int s_wd;
  int e_depth, e_rdata;
  bit e_wready, e_rvalid, e_wmhi, e_wmlo;

  typedef struct {
    bit       wv;
    bit [7:0] wd;
    bit       rr;
    bit       clr;
    bit       pclr;
    bit       wready;
    bit       rvalid;
    bit [7:0] rdata;
    int       depth;
    bit       full;
    bit       wmhi;
    bit       wmlo;
    bit       hievt;
    bit       loevt;
    int       peak;
  } vec_t;

  vec_t tbl[17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nvec++;
    if (actual !== expected) begin
      nerr++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, then compares all outputs against the model before the edge.
  task automatic applyStimulus(input bit wv, input int wd, input bit rr, input bit clr, input bit pclr);
    wvalid_i = wv; wdata_i = 8'(wd); rready_i = rr; clr_i = clr; peak_clr_i = pclr;
    s_wv = wv; s_wd = wd & 8'hFF; s_rr = rr; s_clr = clr; s_pclr = pclr;
    #4;
    e_depth  = q.size();
    e_wready = !m_ur && (e_depth < D);
    e_rvalid = !m_ur && (e_depth > 0 || wv);
    e_rdata  = !e_rvalid ? 0 : (e_depth > 0 ? q[0] : s_wd);
    e_wmhi   = (int'(wm_hi_i) != 0) && (e_depth >= int'(wm_hi_i));
    e_wmlo   = (e_depth <= int'(wm_lo_i));
    checkOutput("depth_o", 32'(depth_o), 32'(e_depth));
    checkOutput("full_o", 32'(full_o), 32'(e_depth == D));
    checkOutput("wready_o", 32'(wready_o), 32'(e_wready));
    checkOutput("rvalid_o", 32'(rvalid_o), 32'(e_rvalid));
    checkOutput("rdata_o", 32'(rdata_o), 32'(e_rdata));
    checkOutput("wm_hi_o", 32'(wm_hi_o), 32'(e_wmhi));
    checkOutput("wm_lo_o", 32'(wm_lo_o), 32'(e_wmlo));
    checkOutput("wm_hi_evt_o", 32'(wm_hi_evt_o), 32'(m_hi_evt));
    checkOutput("wm_lo_evt_o", 32'(wm_lo_evt_o), 32'(m_lo_evt));
    checkOutput("peak_o", 32'(peak_o), 32'(m_peak));
  endtask

  task automatic finishCycle();
    @(posedge clk_i);
    if (s_clr) begin
      q.delete();
      m_peak = 0; hi_seen = 0; lo_seen = 0; m_hi_evt = 0; m_lo_evt = 0;
    end else begin
      if (s_wv && e_wready) q.push_back(s_wd);
      if (s_rr && e_rvalid) void'(q.pop_front());
      m_peak   = s_pclr ? 0 : (e_depth > m_peak ? e_depth : m_peak);
      m_hi_evt = e_wmhi && !hi_seen;
      m_lo_evt = e_wmlo && !lo_seen;
      hi_seen  = e_wmhi;
      lo_seen  = e_wmlo;
    end
    m_ur = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = '{1, 8'h11, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 0, 0, 0, 1, 0, 1, 0};
    tbl[2]  = '{1, 8'h22, 0, 0, 0,  1, 1, 8'h11, 1, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 8'h33, 0, 0, 0,  1, 1, 8'h11, 2, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{1, 8'h44, 0, 0, 0,  1, 1, 8'h11, 3, 0, 1, 0, 0, 0, 2};
    tbl[5]  = '{1, 8'h55, 0, 0, 0,  0, 1, 8'h11, 4, 1, 1, 0, 1, 0, 3};
    tbl[6]  = '{0, 8'h00, 0, 0, 0,  0, 1, 8'h11, 4, 1, 1, 0, 0, 0, 4};
    tbl[7]  = '{0, 8'h00, 1, 0, 0,  0, 1, 8'h11, 4, 1, 1, 0, 0, 0, 4};
    tbl[8]  = '{0, 8'h00, 1, 0, 0,  1, 1, 8'h22, 3, 0, 1, 0, 0, 0, 4};
    tbl[9]  = '{0, 8'h00, 1, 0, 0,  1, 1, 8'h33, 2, 0, 0, 0, 0, 0, 4};
    tbl[10] = '{0, 8'h00, 1, 0, 0,  1, 1, 8'h44, 1, 0, 0, 1, 0, 0, 4};
    tbl[11] = '{0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 4};
    tbl[12] = '{1, 8'h66, 0, 0, 1,  1, 1, 8'h66, 0, 0, 0, 1, 0, 0, 4};
    tbl[13] = '{0, 8'h00, 0, 0, 0,  1, 1, 8'h66, 1, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 8'h00, 1, 0, 0,  1, 1, 8'h66, 1, 0, 0, 1, 0, 0, 1};
    tbl[15] = '{1, 8'hA5, 1, 0, 0,  1, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 1};
    tbl[16] = '{0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1};

    d3_clr = 0; d3_wvalid = 0; d3_rready = 0; d3_peak_clr = 0; d3_wdata = '0;
    d3_wm_hi = '0; d3_wm_lo = '0;
    q.delete(); m_ur = 1; m_peak = 0; hi_seen = 0; lo_seen = 0; m_hi_evt = 0; m_lo_evt = 0;

    rst_ni = 1'b0; clr_i = 0; wvalid_i = 1; wdata_i = 8'h11; rready_i = 0; peak_clr_i = 0;
    wm_hi_i = 3'd3; wm_lo_i = 3'd1;
    repeat (2) @(posedge clk_i);
    #4;
    checkOutput("rst wready_o", 32'(wready_o), 32'd0);
    checkOutput("rst rvalid_o", 32'(rvalid_o), 32'd0);
    checkOutput("rst rdata_o", 32'(rdata_o), 32'd0);
    checkOutput("rst depth_o", 32'(depth_o), 32'd0);
    checkOutput("rst full_o", 32'(full_o), 32'd0);
    checkOutput("rst peak_o", 32'(peak_o), 32'd0);
    checkOutput("rst wm_lo_evt_o", 32'(wm_lo_evt_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].wv, int'(tbl[i].wd), tbl[i].rr, tbl[i].clr, tbl[i].pclr);
      checkOutput($sformatf("tbl[%0d] wready", i), 32'(wready_o), 32'(tbl[i].wready));
      checkOutput($sformatf("tbl[%0d] rvalid", i), 32'(rvalid_o), 32'(tbl[i].rvalid));
      checkOutput($sformatf("tbl[%0d] rdata", i), 32'(rdata_o), 32'(tbl[i].rdata));
      checkOutput($sformatf("tbl[%0d] depth", i), 32'(depth_o), 32'(tbl[i].depth));
      checkOutput($sformatf("tbl[%0d] full", i), 32'(full_o), 32'(tbl[i].full));
      checkOutput($sformatf("tbl[%0d] wm_hi", i), 32'(wm_hi_o), 32'(tbl[i].wmhi));
      checkOutput($sformatf("tbl[%0d] wm_lo", i), 32'(wm_lo_o), 32'(tbl[i].wmlo));
      checkOutput($sformatf("tbl[%0d] hi_evt", i), 32'(wm_hi_evt_o), 32'(tbl[i].hievt));
      checkOutput($sformatf("tbl[%0d] lo_evt", i), 32'(wm_lo_evt_o), 32'(tbl[i].loevt));
      checkOutput($sformatf("tbl[%0d] peak", i), 32'(peak_o), 32'(tbl[i].peak));
      finishCycle();
    end

    // One entry in flight while pushing and popping every cycle walks both pointers through a wrap.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 8'h80 + k, k > 0, 0, 0);
      if (k > 0) checkOutput("wrap rdata", 32'(rdata_o), 32'(8'h80 + k - 1));
      finishCycle();
    end
    applyStimulus(0, 0, 1, 0, 0);
    finishCycle();

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 8'h30 + k, 0, 0, 0);
      finishCycle();
    end
    applyStimulus(1, 8'h3F, 1, 1, 0);
    checkOutput("clr pre depth", 32'(depth_o), 32'd3);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clr depth", 32'(depth_o), 32'd0);
    checkOutput("clr peak", 32'(peak_o), 32'd0);
    checkOutput("clr rvalid", 32'(rvalid_o), 32'd0);
    checkOutput("clr rdata", 32'(rdata_o), 32'd0);
    checkOutput("clr lo_evt first", 32'(wm_lo_evt_o), 32'd0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clr lo_evt repulse", 32'(wm_lo_evt_o), 32'd1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clr lo_evt single", 32'(wm_lo_evt_o), 32'd0);
    finishCycle();

    for (int i = 0; i < 400; i++) begin
      bit fill_phase;
      if (i % 50 == 0) begin
        wm_hi_i = 3'($urandom_range(0, 7));
        wm_lo_i = 3'($urandom_range(0, 7));
      end
      fill_phase = ((i / 40) % 2) == 0;
      applyStimulus(fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 255)),
                    fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 63) == 0,
                    $urandom_range(0, 31) == 0);
      finishCycle();
    end

    // Depth=3 instance: steady occupancy of two while data wraps the odd-sized storage.
    for (int k = 0; k < 12; k++) begin
      d3_wvalid = 1'b1;
      d3_wdata  = 8'(k * 7 + 1);
      d3_rready = (k >= 2);
      applyStimulus(0, 0, 0, 0, 0);
      if (k >= 2) begin
        checkOutput("d3 rdata", 32'(d3_rdata), 32'(8'((k - 2) * 7 + 1)));
        checkOutput("d3 depth", 32'(d3_depth), 32'd2);
      end
      finishCycle();
    end
    d3_wvalid = 1'b0;
    d3_rready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
